dma_read_req_arbiter: RTL and testbench
=======================================

Name: dma_read_req_arbiter

Overview:
- Shares the single PCIe DMA read request channel (addr/len/valid/done plus the tag allocator's current_tag) between p_requesters engines, for example the gather descriptor fetch and several sub-DMA controllers.
- Grants are round-robin. Each issued request is throttled by an outstanding-tag limit.
- The tag consumed by each issued request is returned to its requester so the requester can match packer completions.
- Sits between the DMA engines and the PCIe TX request interface.

Parameters:
- p_requesters, 2, number of requester ports (1..8).
- p_max_outstanding, 16, maximum issued reads whose completion has not yet been released (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- req_addr  in  32*p_requesters  host address; requester i uses bits [32i+31:32i].
- req_len  in  10*p_requesters  length in DW; requester i uses [10i+9:10i]; 0 means 1024 DW, passed through unchanged.
- req_valid  in  p_requesters  request pending; held until the matching req_done.
- req_done  out  p_requesters  one-cycle pulse; request i has been accepted downstream.
- req_tag  out  8  tag of the accepted request; valid only while any req_done bit is set.
- dma_read_addr  out  32  address to PCIe TX.
- dma_read_len  out  10  length to PCIe TX.
- dma_read_valid  out  1  request valid to PCIe TX.
- dma_read_done  in  1  PCIe TX accepted the request and consumed current_tag.
- current_tag  in  8  tag the TX engine assigns to the request being accepted.
- tag_release  in  1  one-cycle pulse; one outstanding read fully completed (driven from packer_done).
- outstanding  out  8  current outstanding count.
- busy  out  1  high while in ISSUE or outstanding != 0.
- err_underflow  out  1  sticky; tag_release arrived while outstanding == 0.

Behaviour:
- Reset (asynchronous, active-high), applies even mid-transfer:
  - state=IDLE, dma_read_valid=0, dma_read_addr=0, dma_read_len=0.
  - outstanding=0, err_underflow=0, last_grant=p_requesters-1, all req_done=0.
- IDLE state:
  - Arbitrate when |req_valid and outstanding < p_max_outstanding.
  - Winner is the first set req_valid bit searching upward from last_grant+1, with modulo wrap.
  - On the next clock: latch the winner index into grant, latch its addr/len into dma_read_addr/len, set dma_read_valid=1, go to ISSUE.
  - Latency is one cycle from req_valid to dma_read_valid.
- ISSUE state:
  - dma_read_valid, addr and len are held stable until dma_read_done.
  - On a cycle with dma_read_done:
    - req_done[grant]=1 and req_tag=current_tag, combinationally in that same cycle.
    - Registered: dma_read_valid<=0, last_grant<=grant, outstanding increments, state<=IDLE.
- Requester obligation: deassert req_valid the cycle after req_done, or re-present a new request.
  - Because req_done is combinational, the arbiter in IDLE sees the updated req_valid.
  - Minimum spacing between consecutive dma_read_valid assertions is one idle cycle.
- Changes on a non-granted requester's req_valid/addr/len during ISSUE are ignored. A granted requester dropping req_valid in ISSUE does not cancel the issue.
- dma_read_done outside ISSUE is ignored: no req_done pulse, no counter change.
- outstanding counter:
  - +1 on an accepted issue; -1 on tag_release.
  - Simultaneous increment and decrement leaves it unchanged.
  - tag_release at 0 leaves it at 0 and sets err_underflow. Only reset clears err_underflow.
- Full condition: outstanding == p_max_outstanding blocks new grants in IDLE. A request already in ISSUE still completes; it cannot overshoot, because the grant was checked against the limit.
- Single requester: back-to-back requests from the same port are allowed; the round-robin pointer simply wraps onto it.

Optional Feature:
- Macro: DMA_RD_ARB_FIXED_PRIO0_EN.
- Defined: requester 0 has strict priority over all others. Round-robin applies only among ports 1..p_requesters-1, and last_grant is updated only by those ports.
- Undefined: pure round-robin over all ports as described in Behaviour.

Test Plan:
- Single request: req0 addr=0x1000_0040 len=16, TX holds done off 3 cycles then asserts with current_tag=0x05 -> dma_read_valid rises 1 cycle after req_valid; addr/len stable 4 cycles; req_done[0] pulses with req_tag=0x05; outstanding=1.
- Fairness: req0 and req1 both continuously valid, done every 2nd cycle -> grants alternate 0,1,0,1. With DMA_RD_ARB_FIXED_PRIO0_EN defined, grants are 0,0,0...
- Limit: p_max_outstanding=2, three requests, no tag_release -> two issues then dma_read_valid stays 0. One tag_release pulse -> third request issues one cycle later.
- Simultaneous: tag_release and dma_read_done in the same cycle with outstanding=1 -> outstanding stays 1.
- Underflow: tag_release with outstanding=0 -> outstanding stays 0, err_underflow=1 until reset.
- Reset mid-ISSUE: assert i_rst asynchronously while dma_read_valid=1 -> dma_read_valid=0 immediately, outstanding=0. After reset, the first grant goes to req0 when req0 and req1 are both valid.

Source files
------------

// File: rtl/dma_read_req_arbiter_if.sv
// Request/issue bundle between the DMA engines, the read request arbiter and the PCIe TX request path.
// The slave modport is the arbiter's view; the master modport is the engines/TX side.
interface dma_read_req_arbiter_if #(
   parameter int unsigned p_requesters = 2
);
   localparam int unsigned p_addr_w = 32;
   localparam int unsigned p_len_w  = 10;
   localparam int unsigned p_tag_w  = 8;
   localparam int unsigned p_cnt_w  = 8;

   logic [p_addr_w*p_requesters-1:0] req_addr;
   logic [p_len_w*p_requesters-1:0]  req_len;
   logic [p_requesters-1:0]          req_valid;
   logic [p_requesters-1:0]          req_done;
   logic [p_tag_w-1:0]               req_tag;
   logic [p_addr_w-1:0]              dma_read_addr;
   logic [p_len_w-1:0]               dma_read_len;
   logic                             dma_read_valid;
   logic                             dma_read_done;
   logic [p_tag_w-1:0]               current_tag;
   logic                             tag_release;
   logic [p_cnt_w-1:0]               outstanding;
   logic                             busy;
   logic                             err_underflow;

   modport slave (
      input  req_addr, req_len, req_valid, dma_read_done, current_tag, tag_release,
      output req_done, req_tag, dma_read_addr, dma_read_len, dma_read_valid,
             outstanding, busy, err_underflow
   );

   modport master (
      output req_addr, req_len, req_valid, dma_read_done, current_tag, tag_release,
      input  req_done, req_tag, dma_read_addr, dma_read_len, dma_read_valid,
             outstanding, busy, err_underflow
   );
endinterface

// File: rtl/dma_read_req_arbiter.sv
// Round-robin arbiter sharing the PCIe DMA read request channel, throttled by an outstanding-read limit.
// Define DMA_RD_ARB_FIXED_PRIO0_EN to give requester 0 strict priority over the round-robin ports.
module dma_read_req_arbiter #(
   parameter int unsigned p_requesters      = 2,
   parameter int unsigned p_max_outstanding = 16
) (
   input logic                   i_clk,
   input logic                   i_rst,
   dma_read_req_arbiter_if.slave bus
);
   localparam int unsigned p_addr_w = 32;
   localparam int unsigned p_len_w  = 10;
   localparam int unsigned p_cnt_w  = 8;
   localparam int unsigned p_idx_w  = (p_requesters > 1) ? $clog2(p_requesters) : 1;
   localparam int unsigned p_rr_n   = (p_requesters > 1) ? p_requesters - 1 : 1;
   localparam logic [p_idx_w-1:0] p_last_rst = p_idx_w'(p_requesters - 1);
   localparam logic [p_cnt_w-1:0] p_limit    = p_cnt_w'(p_max_outstanding);

   typedef enum logic {s_idle, s_issue} state_t;

   state_t             state;
   logic [p_idx_w-1:0] grant;
   logic [p_idx_w-1:0] last_grant;
   logic [p_idx_w-1:0] win_idx;
   logic [p_idx_w-1:0] cand;
   logic               win_found;
   logic               can_grant;
   logic               accept;
   logic               inc;
   logic               dec;
   logic               underflow;
   logic               issue_nxt;
   logic [p_cnt_w-1:0] out_nxt;

   // Winner search starting just above the last granted port, wrapping around
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
`ifdef DMA_RD_ARB_FIXED_PRIO0_EN
      if (bus.req_valid[0]) begin
         win_found = 1'b1;
      end
      for (int unsigned off = 1; off < p_requesters; off++) begin
         cand = p_idx_w'(1 + (32'(last_grant) - 1 + off) % p_rr_n);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`else
      for (int unsigned off = 1; off <= p_requesters; off++) begin
         cand = p_idx_w'((32'(last_grant) + off) % p_requesters);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
`endif
   end

   assign can_grant = win_found && (bus.outstanding < p_limit);
   assign accept    = (state == s_issue) && bus.dma_read_done;
   assign inc       = accept;
   assign dec       = bus.tag_release && (bus.outstanding != '0);
   assign underflow = bus.tag_release && (bus.outstanding == '0);
   assign issue_nxt = ((state == s_idle) && can_grant) || ((state == s_issue) && !bus.dma_read_done);

   always_comb begin
      out_nxt = bus.outstanding;
      if (inc && !dec) begin
         out_nxt = bus.outstanding + p_cnt_w'(1);
      end else if (dec && !inc) begin
         out_nxt = bus.outstanding - p_cnt_w'(1);
      end
   end

   // Completion handshake back to the granted requester, same cycle as the TX accept
   always_comb begin
      bus.req_done = '0;
      bus.req_tag  = '0;
      if (accept) begin
         bus.req_done[grant] = 1'b1;
         bus.req_tag         = bus.current_tag;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state              <= s_idle;
         grant              <= '0;
         last_grant         <= p_last_rst;
         bus.dma_read_valid <= 1'b0;
         bus.dma_read_addr  <= '0;
         bus.dma_read_len   <= '0;
         bus.outstanding    <= '0;
         bus.busy           <= 1'b0;
         bus.err_underflow  <= 1'b0;
      end else begin
         bus.outstanding <= out_nxt;
         bus.busy        <= issue_nxt || (out_nxt != '0);
         if (underflow) begin
            bus.err_underflow <= 1'b1;
         end
         case (state)
            s_idle: begin
               if (can_grant) begin
                  grant              <= win_idx;
                  bus.dma_read_addr  <= bus.req_addr[p_addr_w*win_idx +: p_addr_w];
                  bus.dma_read_len   <= bus.req_len[p_len_w*win_idx +: p_len_w];
                  bus.dma_read_valid <= 1'b1;
                  state              <= s_issue;
               end
            end
            s_issue: begin
               if (bus.dma_read_done) begin
                  bus.dma_read_valid <= 1'b0;
                  state              <= s_idle;
`ifdef DMA_RD_ARB_FIXED_PRIO0_EN
                  if (grant != '0) begin
                     last_grant <= grant;
                  end
`else
                  last_grant <= grant;
`endif
               end
            end
            default: state <= s_idle;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_read_req_arbiter.sv
// Scoreboard bench for dma_read_req_arbiter: requester and TX models drive the bus, a monitor checks each req_done.
`timescale 1ns/1ps
module tb_dma_read_req_arbiter;
   localparam int unsigned NREQ = 2;
   localparam int unsigned MAXO = 2;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   dma_read_req_arbiter_if #(.p_requesters(NREQ)) bus ();

   dma_read_req_arbiter #(.p_requesters(NREQ), .p_max_outstanding(MAXO)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [9:0]  len;
   } rq_t;

   typedef struct {
      logic [NREQ-1:0] done;
      logic [7:0]      tag;
      logic [31:0]     addr;
      logic [9:0]      len;
   } exp_t;

   int n_checks = 0;
   int n_errors = 0;
   exp_t exp_q[$];
   rq_t  pq0[$];
   rq_t  pq1[$];
   logic [7:0] exp_tag = 8'h05;

   // TX model controls
   logic [7:0] tx_tag = 8'h05;
   int tx_delay = 0;
   int tx_cnt = 0;
   int rel_mode = 0;
   int rel_req = 0;
   int rel_cnt = 0;
   int force_req = 0;
   int force_cnt = 0;
   logic forced = 1'b0;
   logic tx_rel;
   logic [NREQ-1:0] done_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int port, input logic [31:0] addr, input logic [9:0] len);
      exp_t e;
      e.done = NREQ'(1) << port;
      e.tag  = exp_tag;
      e.addr = addr;
      e.len  = len;
      exp_q.push_back(e);
      exp_tag = exp_tag + 8'd1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.dma_read_valid) && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_exp(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check("sb_drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // Monitor: every req_done pulse must match the oldest expected issue
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst && bus.req_done != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req_done", 64'(bus.req_done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("req_done", 64'(bus.req_done), 64'(e.done));
               check("req_tag", 64'(bus.req_tag), 64'(e.tag));
               check("issue_addr", 64'(bus.dma_read_addr), 64'(e.addr));
               check("issue_len", 64'(bus.dma_read_len), 64'(e.len));
            end
         end
      end
   end

   // Requester model: presents queue heads, retires a head the cycle after its req_done
   initial begin
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      forever begin
         @(negedge i_clk);
         done_s = bus.req_done;
         @(posedge i_clk);
         #1;
         if (done_s[0] && pq0.size() > 0) void'(pq0.pop_front());
         if (done_s[1] && pq1.size() > 0) void'(pq1.pop_front());
         if (pq0.size() > 0) begin
            bus.req_valid[0]    = 1'b1;
            bus.req_addr[31:0]  = pq0[0].addr;
            bus.req_len[9:0]    = pq0[0].len;
         end else begin
            bus.req_valid[0] = 1'b0;
         end
         if (pq1.size() > 0) begin
            bus.req_valid[1]    = 1'b1;
            bus.req_addr[63:32] = pq1[0].addr;
            bus.req_len[19:10]  = pq1[0].len;
         end else begin
            bus.req_valid[1] = 1'b0;
         end
      end
   end

   // TX model: accepts after tx_delay wait cycles, consumes tags in order, drives tag_release
   initial begin
      bus.dma_read_done = 1'b0;
      bus.current_tag   = tx_tag;
      bus.tag_release   = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         tx_rel = 1'b0;
         if (i_rst) begin
            bus.dma_read_done = 1'b0;
            tx_cnt = 0;
            forced = 1'b0;
         end else begin
            if (bus.dma_read_done) begin
               bus.dma_read_done = 1'b0;
               if (!forced) begin
                  tx_tag = tx_tag + 8'd1;
                  if (rel_mode == 1) tx_rel = 1'b1;
               end
               forced = 1'b0;
               tx_cnt = 0;
            end else if (bus.dma_read_valid) begin
               if (tx_cnt >= tx_delay) begin
                  bus.dma_read_done = 1'b1;
                  if (rel_mode == 2) tx_rel = 1'b1;
               end else begin
                  tx_cnt++;
               end
            end else if (force_req != force_cnt) begin
               force_cnt++;
               bus.dma_read_done = 1'b1;
               forced = 1'b1;
            end
            if (!tx_rel && rel_req != rel_cnt) begin
               rel_cnt++;
               tx_rel = 1'b1;
            end
         end
         bus.tag_release = tx_rel;
         bus.current_tag = tx_tag;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      cycles(3);
      check("rst_valid", 64'(bus.dma_read_valid), 64'd0);
      check("rst_addr", 64'(bus.dma_read_addr), 64'd0);
      check("rst_len", 64'(bus.dma_read_len), 64'd0);
      check("rst_outstanding", 64'(bus.outstanding), 64'd0);
      check("rst_err", 64'(bus.err_underflow), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_req_done", 64'(bus.req_done), 64'd0);
      i_rst = 1'b0;
      cycles(1);

      // Single request, TX holds done off three cycles
      tx_delay = 3;
      pq0.push_back('{32'h1000_0040, 10'd16});
      push_exp(0, 32'h1000_0040, 10'd16);
      cycles(1);
      check("t1_req_valid", 64'(bus.req_valid[0]), 64'd1);
      check("t1_latency_pre", 64'(bus.dma_read_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         cycles(1);
         check("t1_valid_hold", 64'(bus.dma_read_valid), 64'd1);
         check("t1_addr_hold", 64'(bus.dma_read_addr), 64'h1000_0040);
         check("t1_len_hold", 64'(bus.dma_read_len), 64'd16);
      end
      cycles(1);
      check("t1_valid_drop", 64'(bus.dma_read_valid), 64'd0);
      check("t1_outstanding", 64'(bus.outstanding), 64'd1);
      check("t1_busy", 64'(bus.busy), 64'd1);
      rel_req++;
      cycles(3);
      check("t1_released", 64'(bus.outstanding), 64'd0);
      check("t1_idle_busy", 64'(bus.busy), 64'd0);

      // Fairness: both ports continuously valid, accept on every second cycle
      tx_delay = 0;
      rel_mode = 1;
      for (int i = 0; i < 4; i++) begin
         pq0.push_back('{32'h2000_0000 + 32'(i * 64), 10'(i + 1)});
         pq1.push_back('{32'h3000_0000 + 32'(i * 128), 10'(i * 3)});
      end
`ifdef DMA_RD_ARB_FIXED_PRIO0_EN
      for (int i = 0; i < 4; i++) push_exp(0, 32'h2000_0000 + 32'(i * 64), 10'(i + 1));
      for (int i = 0; i < 4; i++) push_exp(1, 32'h3000_0000 + 32'(i * 128), 10'(i * 3));
`else
      // last grant was port 0, so port 1 leads
      for (int i = 0; i < 4; i++) begin
         push_exp(1, 32'h3000_0000 + 32'(i * 128), 10'(i * 3));
         push_exp(0, 32'h2000_0000 + 32'(i * 64), 10'(i + 1));
      end
`endif
      wait_idle(100);
      cycles(2);
      check("t2_outstanding", 64'(bus.outstanding), 64'd0);

      // Limit: three requests, no releases
      rel_mode = 0;
      pq0.push_back('{32'h4000_0000, 10'd8});
      pq0.push_back('{32'h4000_1000, 10'd9});
      pq0.push_back('{32'h4000_2000, 10'd10});
      push_exp(0, 32'h4000_0000, 10'd8);
      push_exp(0, 32'h4000_1000, 10'd9);
      wait_exp(50);
      for (int k = 0; k < 4; k++) begin
         cycles(1);
         check("t3_blocked", 64'(bus.dma_read_valid), 64'd0);
      end
      check("t3_full", 64'(bus.outstanding), 64'd2);
      check("t3_busy", 64'(bus.busy), 64'd1);
      check("t3_still_pending", 64'(bus.req_valid[0]), 64'd1);
      push_exp(0, 32'h4000_2000, 10'd10);
      rel_req++;
      cycles(1);
      check("t3_rel_cycle_out", 64'(bus.outstanding), 64'd2);
      cycles(1);
      check("t3_after_rel_out", 64'(bus.outstanding), 64'd1);
      check("t3_after_rel_valid", 64'(bus.dma_read_valid), 64'd0);
      cycles(1);
      check("t3_third_valid", 64'(bus.dma_read_valid), 64'd1);
      check("t3_third_addr", 64'(bus.dma_read_addr), 64'h4000_2000);
      wait_idle(20);
      check("t3_out_final", 64'(bus.outstanding), 64'd2);

      // Simultaneous accept and release at outstanding == 1
      rel_req++;
      cycles(3);
      check("t4_pre_out", 64'(bus.outstanding), 64'd1);
      rel_mode = 2;
      pq1.push_back('{32'h5000_0080, 10'd0});
      push_exp(1, 32'h5000_0080, 10'd0);
      wait_idle(20);
      cycles(1);
      check("t4_simul_out", 64'(bus.outstanding), 64'd1);
      check("t4_no_err", 64'(bus.err_underflow), 64'd0);
      rel_mode = 0;

      // Stray dma_read_done outside ISSUE is ignored
      force_req++;
      cycles(3);
      check("t4b_stray_done_out", 64'(bus.outstanding), 64'd1);

      // Underflow
      rel_req++;
      cycles(3);
      check("t5_zero", 64'(bus.outstanding), 64'd0);
      check("t5_err_clear", 64'(bus.err_underflow), 64'd0);
      rel_req++;
      cycles(3);
      check("t5_stay_zero", 64'(bus.outstanding), 64'd0);
      check("t5_err_set", 64'(bus.err_underflow), 64'd1);
      cycles(5);
      check("t5_err_sticky", 64'(bus.err_underflow), 64'd1);
      check("t5_busy", 64'(bus.busy), 64'd0);

      // Reset in the middle of an issue
      tx_delay = 0;
      pq0.push_back('{32'h6000_0000, 10'd4});
      push_exp(0, 32'h6000_0000, 10'd4);
      wait_idle(20);
      check("t6_pre_out", 64'(bus.outstanding), 64'd1);
      tx_delay = 20;
      pq0.push_back('{32'h7000_0000, 10'd5});
      pq1.push_back('{32'h7100_0000, 10'd6});
      begin
         int n;
         n = 0;
         while (!bus.dma_read_valid && n < 10) begin
            cycles(1);
            n++;
         end
      end
      check("t6_issue_port1", 64'(bus.dma_read_addr), 64'h7100_0000);
      cycles(2);
      #2;
      i_rst = 1'b1;
      #1;
      check("t6_rst_valid", 64'(bus.dma_read_valid), 64'd0);
      check("t6_rst_out", 64'(bus.outstanding), 64'd0);
      check("t6_rst_err", 64'(bus.err_underflow), 64'd0);
      check("t6_rst_addr", 64'(bus.dma_read_addr), 64'd0);
      tx_delay = 0;
      push_exp(0, 32'h7000_0000, 10'd5);
      push_exp(1, 32'h7100_0000, 10'd6);
      cycles(2);
      i_rst = 1'b0;
      wait_idle(40);
      check("t6_final_out", 64'(bus.outstanding), 64'd2);

      cycles(3);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
